// File: rtl/signed_adder8_if.sv
// Operand/result bundle for the registered signed adder.
// Carries no logic: the master drives operands and enable, and the slave returns the registered results.
// There is no backpressure, so a new operand pair may be presented on every cycle.
interface signed_adder8_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] inp1;
  logic [WIDTH-1:0] inp2;
  logic             enable;
  logic [WIDTH-1:0] sum;
  logic             overflow_flag;

  modport master (
    output inp1,
    output inp2,
    output enable,
    input  sum,
    input  overflow_flag
  );

  modport slave (
    input  inp1,
    input  inp2,
    input  enable,
    output sum,
    output overflow_flag
  );
endinterface

// File: rtl/signed_adder8.sv
// Registered two's-complement adder that also produces a signed-overflow flag.
// Latency is 1 clock from operand/enable sampling to sum/overflow_flag; throughput is one pair per cycle.
// There is no backpressure; enable=0 holds both outputs and ignores the operands.
module signed_adder8 #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  signed_adder8_if.slave  bus
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] raw;
  logic             ovf;

  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic             ovf_q;
  logic             ovf_d;

  // Ripple-carry chain with carry-in 0. The final carry-out is used only for overflow detection.
  always_comb begin
    carry = '0;
    raw   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      raw[i]     = bus.inp1[i] ^ bus.inp2[i] ^ carry[i];
      carry[i+1] = (bus.inp1[i] & bus.inp2[i]) |
                   (carry[i] & (bus.inp1[i] ^ bus.inp2[i]));
    end
  end

  // Signed overflow occurs when the carry into the MSB differs from the carry out of it.
  // This is the same as two like-signed operands producing a result of the opposite sign.
  assign ovf = carry[WIDTH] ^ carry[MSB];

  // Next state: capture on enable, otherwise hold.
  // The operands are never selected while enable is 0, so unknown operands cannot reach the registers.
  always_comb begin
    sum_d = sum_q;
    ovf_d = ovf_q;
    if (bus.enable) begin
      sum_d = raw;
      ovf_d = ovf;
    end
  end

  // Output registers: synchronous reset takes priority over capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.sum           = sum_q;
  assign bus.overflow_flag = ovf_q;

endmodule

// File: tb/tb_signed_adder8.sv
// Directed self-checking bench for signed_adder8.
// Each scenario task drives operands, waits on clock edges and compares the registered outputs.
// Results are sampled 1ns after the rising edge, and the run ends with a single summary line.
module tb_signed_adder8;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  signed_adder8_if #(.WIDTH(8)) bus ();

  signed_adder8 #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.inp1 = 8'h5A;
    bus.inp2 = 8'h33;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.sum !== 8'h00 || bus.overflow_flag !== 1'b0) begin
        errors++;
        $display("FAIL reset_edge%0d: got sum=%h ovf=%b, want sum=00 ovf=0",
                 i, bus.sum, bus.overflow_flag);
      end
    end
    reset = 1'b0;
    bus.enable = 1'b0;
    bus.inp1 = 8'h7F;
    bus.inp2 = 8'h7F;
    tick();
    checks++;
    if (bus.sum !== 8'h00 || bus.overflow_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_hold: got sum=%h ovf=%b, want sum=00 ovf=0",
               bus.sum, bus.overflow_flag);
    end
  endtask

  task automatic test_mixed_wrap();
    bus.enable = 1'b1;
    bus.inp1 = 8'h01;
    bus.inp2 = 8'hFF;
    tick();
    checks++;
    if (bus.sum !== 8'h00 || bus.overflow_flag !== 1'b0) begin
      errors++;
      $display("FAIL mixed_wrap: got sum=%h ovf=%b, want sum=00 ovf=0",
               bus.sum, bus.overflow_flag);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] a  [3];
    logic [7:0] b  [3];
    logic [7:0] es [3];
    logic       eo [3];
    a[0] = 8'h7F; b[0] = 8'h01; es[0] = 8'h80; eo[0] = 1'b1;
    a[1] = 8'h81; b[1] = 8'hFF; es[1] = 8'h80; eo[1] = 1'b0;
    a[2] = 8'h80; b[2] = 8'hFF; es[2] = 8'h7F; eo[2] = 1'b1;
    bus.enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.inp1 = a[i];
      bus.inp2 = b[i];
      tick();
      checks++;
      if (bus.sum !== es[i] || bus.overflow_flag !== eo[i]) begin
        errors++;
        $display("FAIL overflow_%0d (%h+%h): got sum=%h ovf=%b, want sum=%h ovf=%b",
                 i, a[i], b[i], bus.sum, bus.overflow_flag, es[i], eo[i]);
      end
    end
  endtask

  task automatic test_normal();
    bus.enable = 1'b1;
    bus.inp1 = 8'hF9;
    bus.inp2 = 8'hFF;
    tick();
    checks++;
    if (bus.sum !== 8'hF8 || bus.overflow_flag !== 1'b0) begin
      errors++;
      $display("FAIL normal_neg: got sum=%h ovf=%b, want sum=F8 ovf=0",
               bus.sum, bus.overflow_flag);
    end
    bus.inp1 = 8'h01;
    bus.inp2 = 8'h03;
    tick();
    checks++;
    if (bus.sum !== 8'h04 || bus.overflow_flag !== 1'b0) begin
      errors++;
      $display("FAIL normal_pos: got sum=%h ovf=%b, want sum=04 ovf=0",
               bus.sum, bus.overflow_flag);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a  [5];
    logic [7:0] b  [5];
    logic [7:0] es [5];
    logic       eo [5];
    a[0] = 8'h40; b[0] = 8'h40; es[0] = 8'h80; eo[0] = 1'b1;
    a[1] = 8'hC0; b[1] = 8'hC0; es[1] = 8'h80; eo[1] = 1'b0;
    a[2] = 8'h7F; b[2] = 8'h80; es[2] = 8'hFF; eo[2] = 1'b0;
    a[3] = 8'h80; b[3] = 8'h80; es[3] = 8'h00; eo[3] = 1'b1;
    a[4] = 8'h10; b[4] = 8'h25; es[4] = 8'h35; eo[4] = 1'b0;
    bus.enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.inp1 = a[i];
      bus.inp2 = b[i];
      tick();
      checks++;
      if (bus.sum !== es[i] || bus.overflow_flag !== eo[i]) begin
        errors++;
        $display("FAIL b2b_%0d (%h+%h): got sum=%h ovf=%b, want sum=%h ovf=%b",
                 i, a[i], b[i], bus.sum, bus.overflow_flag, es[i], eo[i]);
      end
    end
  endtask

  task automatic test_enable_hold();
    bus.enable = 1'b1;
    bus.inp1 = 8'h7F;
    bus.inp2 = 8'h01;
    tick();
    checks++;
    if (bus.sum !== 8'h80 || bus.overflow_flag !== 1'b1) begin
      errors++;
      $display("FAIL hold_capture: got sum=%h ovf=%b, want sum=80 ovf=1",
               bus.sum, bus.overflow_flag);
    end
    bus.enable = 1'b0;
    bus.inp1 = 8'h01;
    bus.inp2 = 8'h01;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.sum !== 8'h80 || bus.overflow_flag !== 1'b1) begin
        errors++;
        $display("FAIL hold_edge%0d: got sum=%h ovf=%b, want sum=80 ovf=1",
                 i, bus.sum, bus.overflow_flag);
      end
    end
    bus.inp1 = 8'hxx;
    bus.inp2 = 8'hxx;
    tick();
    checks++;
    if (bus.sum !== 8'h80 || bus.overflow_flag !== 1'b1) begin
      errors++;
      $display("FAIL hold_x_operands: got sum=%h ovf=%b, want sum=80 ovf=1",
               bus.sum, bus.overflow_flag);
    end
    bus.enable = 1'b1;
    bus.inp1 = 8'h01;
    bus.inp2 = 8'h01;
    tick();
    checks++;
    if (bus.sum !== 8'h02 || bus.overflow_flag !== 1'b0) begin
      errors++;
      $display("FAIL hold_reenable: got sum=%h ovf=%b, want sum=02 ovf=0",
               bus.sum, bus.overflow_flag);
    end
  endtask

  task automatic test_reset_priority();
    bus.enable = 1'b1;
    bus.inp1 = 8'h7F;
    bus.inp2 = 8'h01;
    reset = 1'b1;
    tick();
    checks++;
    if (bus.sum !== 8'h00 || bus.overflow_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority: got sum=%h ovf=%b, want sum=00 ovf=0",
               bus.sum, bus.overflow_flag);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.sum !== 8'h80 || bus.overflow_flag !== 1'b1) begin
      errors++;
      $display("FAIL reset_then_capture: got sum=%h ovf=%b, want sum=80 ovf=1",
               bus.sum, bus.overflow_flag);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.inp1 = 8'h00;
    bus.inp2 = 8'h00;
    #2;
    test_reset();
    test_mixed_wrap();
    test_overflow();
    test_normal();
    test_back_to_back();
    test_enable_hold();
    test_reset_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/signed_adder8.md
Name: signed_adder8

Overview:
- Registered 8-bit two's-complement adder with a signed-overflow flag.
- Adds two signed operands, captures the sum and overflow in output registers on the clock edge when enabled, and holds them otherwise.
- Intended as a small arithmetic leaf block feeding datapath or status logic that needs a one-cycle-registered signed sum.

Parameters:
- WIDTH, 8, operand/sum width in bits. Must be ≥2. All behaviour below is stated for 8; it generalises with MSB = WIDTH-1.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- inp1  input  WIDTH  signed two's-complement operand A.
- inp2  input  WIDTH  signed two's-complement operand B.
- enable  input  1  load enable for the output registers.
- overflow_flag  output  1  registered signed-overflow indication for the captured sum.
- sum  output  WIDTH  registered two's-complement sum, inp1+inp2 modulo 2^WIDTH.

Behaviour:
- Reset:
  - Reset is sampled only on a rising clk edge, with no asynchronous path.
  - When reset=1 at the edge: sum <= 0 and overflow_flag <= 0, regardless of enable or operands.
  - Reset has priority over enable.
- Compute:
  - Combinational ripple-carry chain of WIDTH full adders with carry-in 0.
  - raw = inp1 + inp2, truncated to WIDTH bits.
  - Carry-out of the MSB is discarded and is not an output.
- Overflow:
  - ovf = (inp1[MSB] == inp2[MSB]) && (raw[MSB] != inp1[MSB]).
  - Equivalently, carry into the MSB XOR carry out of the MSB.
  - Adding operands of opposite sign never overflows.
- Capture:
  - On a rising edge with reset=0 and enable=1: sum <= raw, overflow_flag <= ovf.
  - Latency is exactly 1 clock from operand/enable sampling to outputs.
  - A new pair may be presented every cycle (throughput 1/cycle).
- Hold:
  - On a rising edge with reset=0 and enable=0, both outputs keep their previous values.
  - Operand changes while enable=0 have no effect.
- No saturation: on overflow, sum is the wrapped result and only the flag indicates the error.
- Outputs are driven only from registers, with no combinational path from inputs to outputs.
- overflow_flag is not sticky. It reflects only the most recently captured addition.
- X/unknown operands while enable=0 must not propagate to outputs.
- Reset mid-stream: a reset edge clears outputs immediately. The first enabled edge after reset deasserts captures normally.

Test Plan:
- Reset: assert reset for 2 edges with arbitrary inputs -> sum=0x00, overflow_flag=0. Deassert reset with enable=0 -> outputs stay 0.
- Mixed signs, wrap with carry-out: inp1=0x01, inp2=0xFF (1 + −1), enable=1 -> one edge later sum=0x00, overflow_flag=0. The discarded carry must not set the flag.
- Positive overflow: inp1=0x7F, inp2=0x01 -> sum=0x80, overflow_flag=1. Negative overflow: inp1=0x81, inp2=0xFF (−127 + −1 = −128, no overflow) -> sum=0x80, flag=0. Then inp1=0x80, inp2=0xFF -> sum=0x7F, flag=1.
- Normal negative and positive sums: 0xF9+0xFF (−7 + −1) -> sum=0xF8, flag=0. 0x01+0x03 -> sum=0x04, flag=0. Back-to-back on consecutive cycles, each result appears exactly one edge after its operands.
- Enable hold: capture 0x7F+0x01 (sum=0x80, flag=1), then drop enable and apply 0x01+0x01 for 3 edges -> outputs remain 0x80/1. Re-assert enable -> sum=0x02, flag=0 one edge later.
- Reset priority mid-operation: enable=1 with 0x7F+0x01 and reset=1 on the same edge -> sum=0x00, flag=0. Next edge with reset=0 -> sum=0x80, flag=1.
